cpu_traffic_gen: RTL
====================

CPU_TRAFFIC_GEN -- requirements
Module: cpu_traffic_gen

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 26; CPU word-address MSB, address bus is [ADDR_BITS:1].
REQ-002 SHALL have parameter NUM_XFERS, default 256; word transfers per phase, range 1..65535.
REQ-003 SHALL have parameter GAP_CYCLES, default 4; idle cycles between transfers, range 1..15.
REQ-004 SHALL have parameter LFSR_SEED, default 32'hACE1_1234; non-zero LFSR start value.
REQ-005 SHALL have parameter TIMEOUT, default 1023; maximum cycles waiting for cpuena per transfer.
REQ-006 SHALL use one clock and a synchronous, active-high reset, per the port list below.
REQ-007 clk_114  in  1  system clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 start  in  1  single-cycle run request; sampled only in IDLE.
REQ-010 mode  in  2  address pattern: 00 sequential, 01 stride, 10 LFSR, 11 treated as 00.
REQ-011 stride  in  8  word stride for mode 01; latched at start.
REQ-012 base_addr  in  ADDR_BITS  base word address [ADDR_BITS:1]; latched at start.
REQ-013 cpuAddr  out  ADDR_BITS  word address to sdram_ctrl cpuAddr.
REQ-014 cpustate  out  4  {longword, ncs, state[1:0]} to sdram_ctrl cpustate.
REQ-015 cpuL, cpuU  out  1 each  active-low byte enables.
REQ-016 cpuWR  out  16  write data.
REQ-017 cpuRD  in  16  read data from sdram_ctrl.
REQ-018 cpuena  in  1  transfer-complete strobe from sdram_ctrl.
REQ-019 busy  out  1  high in every state except IDLE and DONE.
REQ-020 done  out  1  high in DONE.
REQ-021 err  out  1  sticky: at least one miscompare or a timeout.
REQ-022 timeout  out  1  sticky: run aborted on cpuena timeout.
REQ-023 err_count  out  16  saturating miscompare count.
REQ-024 err_addr  out  ADDR_BITS  address of the first miscompare.

Function
REQ-025 FSM states: IDLE, WR, WGAP, RD, RGAP, DONE.
- IDLE -> WR on start.
- WR -> WGAP on cpuena.
- WGAP -> WR after GAP_CYCLES cycles, or -> RD after the NUM_XFERS-th write (address generator re-initialised).
- RD -> RGAP on cpuena.
- RGAP -> RD after GAP_CYCLES cycles, or -> DONE after the NUM_XFERS-th read.
- DONE -> IDLE on start; that same start is not a new run.
REQ-026 In WR, drive cpustate=4'b0011 (write, ncs=0); in RD, drive 4'b0010 (read, ncs=0); in all other states drive 4'b0101 (idle, ncs=1); longword is always 0.
REQ-027 cpuL=cpuU=0 in WR/RD and 1 otherwise; cpuAddr and cpuWR SHALL be stable for the whole of WR or RD.
REQ-028 Address for transfer i, modulo 2^ADDR_BITS:
- mode 00: base + i.
- mode 01: base + i*stride, accumulated, no multiplier.
- mode 10: base XOR lfsr[ADDR_BITS-1:0]; 32-bit Galois LFSR, taps 32,22,2,1, seeded with LFSR_SEED at start and at the WGAP->RD transition, stepped once per completed transfer.
REQ-029 Data SHALL be a function of address only: cpuWR = cpuAddr[16:1] XOR 16'h5A5A. Address collisions therefore never give false errors.
REQ-030 Read compare on the cpuena cycle in RD: if cpuRD differs from the expected data, set err and increment err_count (saturating at 16'hFFFF); load err_addr only when err_count was 0.
REQ-031 A wait counter clears on entry to WR/RD. If it reaches TIMEOUT without cpuena, set err and timeout and go directly to DONE.
REQ-032 cpuena outside WR/RD SHALL be ignored. cpuena on the WR/RD entry cycle SHALL count as completion.
REQ-033 start SHALL be ignored while busy. err, timeout, err_count and err_addr SHALL clear on an accepted start from IDLE and hold through DONE.

Reset
REQ-034 With reset high at a clock edge, regardless of state:
- state IDLE; cpustate 4'b0101; cpuL=cpuU=1; cpuAddr=0; cpuWR=0.
- busy, done, err, timeout = 0; err_count=0; err_addr=0; LFSR=LFSR_SEED.
- A reset mid-transfer SHALL release the bus (ncs=1) on the next cycle.

Verification
REQ-035 mode 00, base 0x100, NUM_XFERS 4, ideal memory acks in 3 cycles -> writes to 0x100..0x103 with data 0x5B5A,0x5B5B,0x5B58,0x5B59; reads match; done=1, err=0.
REQ-036 mode 01, stride 0xFF, base all-ones minus 1 -> addresses wrap mod 2^ADDR_BITS; no error.
REQ-037 mode 10, memory corrupting bit 0 on the third read -> err=1, err_count=1, err_addr equals the third LFSR address.
REQ-038 cpuena never asserted -> after TIMEOUT+1 cycles in WR: timeout=1, err=1, done=1.
REQ-039 reset asserted during RD -> next cycle cpustate=4'b0101, busy=0; a new start runs a clean pass.
REQ-040 start pulsed while busy -> ignored; run completes with exactly NUM_XFERS writes and NUM_XFERS reads.

Source files
------------

// File: rtl/cpu_traffic_gen_if.sv
// CPU-side sdram_ctrl bus: address, cpustate, byte enables, write/read data, cpuena.
// master = traffic generator, slave = sdram_ctrl or a memory model.
interface cpu_traffic_gen_if #(
    parameter int ADDR_BITS = 26
);
    logic [ADDR_BITS:1] cpuAddr;
    logic [3:0]         cpustate;
    logic               cpuL;
    logic               cpuU;
    logic [15:0]        cpuWR;
    logic [15:0]        cpuRD;
    logic               cpuena;

    modport master (
        output cpuAddr, cpustate, cpuL, cpuU, cpuWR,
        input  cpuRD, cpuena
    );

    modport slave (
        input  cpuAddr, cpustate, cpuL, cpuU, cpuWR,
        output cpuRD, cpuena
    );
endinterface

// File: rtl/cpu_traffic_gen.sv
// cpu_traffic_gen: writes NUM_XFERS address-derived words, reads them back and checks.
// Ports: clk_114/reset, start/mode/stride/base_addr run setup, bus (master side of
// the sdram_ctrl CPU port), busy/done status, err/timeout/err_count/err_addr results.
module cpu_traffic_gen #(
    parameter int          ADDR_BITS  = 26,
    parameter int          NUM_XFERS  = 256,
    parameter int          GAP_CYCLES = 4,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_1234,
    parameter int          TIMEOUT    = 1023
) (
    input  logic                clk_114,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [7:0]          stride,
    input  logic [ADDR_BITS:1]  base_addr,
    cpu_traffic_gen_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                timeout,
    output logic [15:0]         err_count,
    output logic [ADDR_BITS:1]  err_addr
);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_WGAP = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_RGAP = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]           state;
    logic [1:0]           mode_q;
    logic [7:0]           stride_q;
    logic [ADDR_BITS:1]   base_q;
    logic [ADDR_BITS-1:0] acc;
    logic [31:0]          lfsr;
    logic [15:0]          xfer_cnt;
    logic [3:0]           gap_cnt;
    logic [WW-1:0]        wait_cnt;
    logic [ADDR_BITS:1]   addr_q;
    logic [15:0]          wdata_q;

    logic [ADDR_BITS:1]   start_addr;
    logic [ADDR_BITS:1]   next_addr;
    logic [ADDR_BITS:1]   rest_addr;
    logic [ADDR_BITS-1:0] inc;
    logic [31:0]          lfsr_next;
    logic                 gap_last;
    logic                 xfer_last;
    logic                 wait_last;

    // Sequential and stride modes share one offset accumulator; LFSR mode
    // ignores it and XORs the base with the LFSR low bits instead.
    function automatic logic [ADDR_BITS:1] gen_addr(
        input logic [ADDR_BITS:1]   b,
        input logic [1:0]           m,
        input logic [ADDR_BITS-1:0] off,
        input logic [ADDR_BITS-1:0] l
    );
        if (m == 2'b10) return b ^ l;
        return b + off;
    endfunction

    function automatic logic [15:0] data_of(input logic [ADDR_BITS:1] a);
        return a[16:1] ^ 16'h5A5A;
    endfunction

    assign start_addr = gen_addr(base_addr, mode, '0, LFSR_SEED[ADDR_BITS-1:0]);
    assign next_addr  = gen_addr(base_q, mode_q, acc, lfsr[ADDR_BITS-1:0]);
    assign rest_addr  = gen_addr(base_q, mode_q, '0, LFSR_SEED[ADDR_BITS-1:0]);

    assign inc = (mode_q == 2'b01) ? {{(ADDR_BITS-8){1'b0}}, stride_q}
                                   : ADDR_BITS'(1);

    // Galois form of x^32 + x^22 + x^2 + x + 1
    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);

    assign gap_last  = (gap_cnt == 4'(GAP_CYCLES - 1));
    assign xfer_last = (xfer_cnt == 16'(NUM_XFERS));
    assign wait_last = (wait_cnt == WW'(TIMEOUT));

    always_ff @(posedge clk_114) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            stride_q  <= '0;
            base_q    <= '0;
            acc       <= '0;
            lfsr      <= LFSR_SEED;
            xfer_cnt  <= '0;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err       <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_WR;
                        mode_q    <= mode;
                        stride_q  <= stride;
                        base_q    <= base_addr;
                        acc       <= '0;
                        lfsr      <= LFSR_SEED;
                        xfer_cnt  <= '0;
                        wait_cnt  <= '0;
                        addr_q    <= start_addr;
                        wdata_q   <= data_of(start_addr);
                        err       <= 1'b0;
                        timeout   <= 1'b0;
                        err_count <= '0;
                        err_addr  <= '0;
                    end
                end
                S_WR, S_RD: begin
                    if (bus.cpuena) begin
                        state    <= (state == S_WR) ? S_WGAP : S_RGAP;
                        gap_cnt  <= '0;
                        xfer_cnt <= xfer_cnt + 16'd1;
                        acc      <= acc + inc;
                        lfsr     <= lfsr_next;
                        if (state == S_RD && bus.cpuRD != wdata_q) begin
                            err <= 1'b1;
                            if (err_count == 16'h0) err_addr <= addr_q;
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        end
                    end else if (wait_last) begin
                        state   <= S_DONE;
                        err     <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_WGAP: begin
                    if (gap_last) begin
                        wait_cnt <= '0;
                        if (xfer_last) begin
                            // write phase over: replay the same address sequence
                            state    <= S_RD;
                            xfer_cnt <= '0;
                            acc      <= '0;
                            lfsr     <= LFSR_SEED;
                            addr_q   <= rest_addr;
                            wdata_q  <= data_of(rest_addr);
                        end else begin
                            state   <= S_WR;
                            addr_q  <= next_addr;
                            wdata_q <= data_of(next_addr);
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_RGAP: begin
                    if (gap_last) begin
                        wait_cnt <= '0;
                        if (xfer_last) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_RD;
                            addr_q  <= next_addr;
                            wdata_q <= data_of(next_addr);
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    if (start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.cpustate = 4'b0101;
        bus.cpuL     = 1'b1;
        bus.cpuU     = 1'b1;
        if (state == S_WR) begin
            bus.cpustate = 4'b0011;
            bus.cpuL     = 1'b0;
            bus.cpuU     = 1'b0;
        end else if (state == S_RD) begin
            bus.cpustate = 4'b0010;
            bus.cpuL     = 1'b0;
            bus.cpuU     = 1'b0;
        end
    end

    assign bus.cpuAddr = addr_q;
    assign bus.cpuWR   = wdata_q;
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);
endmodule
